// File: rtl/mem_port_scheduler_if.sv
// rtl/mem_port_scheduler_if.sv - store/load/memory signal bundle for the data-memory port scheduler
interface mem_port_scheduler_if #(
  parameter int TAG_W = 6
);
  logic             IN_stValid;
  logic [31:0]      IN_stAddr;
  logic [31:0]      IN_stData;
  logic [3:0]       IN_stMask;
  logic             OUT_stReady;
  logic             OUT_empty;

  logic             IN_ldValid;
  logic [31:0]      IN_ldAddr;
  logic [TAG_W-1:0] IN_ldTag;
  logic             OUT_ldReady;
  logic             OUT_ldValid;
  logic [TAG_W-1:0] OUT_ldTag;
  logic [31:0]      OUT_ldData;

  logic             OUT_memEn;
  logic             OUT_memWe;
  logic [29:0]      OUT_memAddr;
  logic [31:0]      OUT_memWData;
  logic [3:0]       OUT_memWMask;
  logic [31:0]      IN_memRData;
  logic             IN_IO_busy;

  modport slave (
    input  IN_stValid, IN_stAddr, IN_stData, IN_stMask,
    output OUT_stReady, OUT_empty,
    input  IN_ldValid, IN_ldAddr, IN_ldTag,
    output OUT_ldReady, OUT_ldValid, OUT_ldTag, OUT_ldData,
    output OUT_memEn, OUT_memWe, OUT_memAddr, OUT_memWData, OUT_memWMask,
    input  IN_memRData, IN_IO_busy
  );

  modport master (
    output IN_stValid, IN_stAddr, IN_stData, IN_stMask,
    input  OUT_stReady, OUT_empty,
    output IN_ldValid, IN_ldAddr, IN_ldTag,
    input  OUT_ldReady, OUT_ldValid, OUT_ldTag, OUT_ldData,
    input  OUT_memEn, OUT_memWe, OUT_memAddr, OUT_memWData, OUT_memWMask,
    output IN_memRData, IN_IO_busy
  );
endinterface

// File: rtl/mem_port_scheduler.sv
// rtl/mem_port_scheduler.sv - arbitrates the single data-memory port between buffered committed stores and load reads
module mem_port_scheduler #(
  parameter int DEPTH      = 4,
  parameter int HI_WATER   = 3,
  parameter int MAX_STARVE = 7,
  parameter int TAG_W      = 6
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_scheduler_if.slave sched
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] HI_C     = CNT_W'(HI_WATER);
  localparam logic [STV_W-1:0] STARVE_C = STV_W'(MAX_STARVE);

  logic [29:0]      fifo_addr_q [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [3:0]       fifo_mask_q [DEPTH];
  logic [DEPTH-1:0] fifo_vld_q, fifo_vld_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             io_hold_q, io_hold_d;
  logic             st_ready_q, empty_q;

  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [29:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q;
  logic [3:0]       mem_wmask_q;

  logic             ld_v1_q, ld_v2_q, ld_vo_q;
  logic [TAG_W-1:0] ld_t1_q, ld_t2_q, ld_to_q;
  logic [31:0]      ld_data_q;

  logic [29:0]      head_addr;
  logic [31:0]      head_data;
  logic [3:0]       head_mask;
  logic             st_avail, st_io, st_elig, st_force;
  logic             ld_hit, ld_ready, ld_issue, st_issue, push;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^{sched.IN_stAddr[1:0], sched.IN_ldAddr[1:0]};

  assign head_addr = fifo_addr_q[head_q];
  assign head_data = fifo_data_q[head_q];
  assign head_mask = fifo_mask_q[head_q];

  // Head address is a word address, so the MMIO page byte lives in bits 29:22.
  assign st_avail = (count_q != '0);
  assign st_io    = (head_addr[29:22] == 8'hFF);
  assign st_elig  = st_avail && !(st_io && (sched.IN_IO_busy || io_hold_q));
  assign st_force = st_elig && ((count_q >= HI_C) || (starve_q >= STARVE_C));

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld_q[i] && (fifo_addr_q[i] == sched.IN_ldAddr[31:2])) begin
        ld_hit = sched.IN_ldValid;
      end
    end
  end

  assign ld_ready = !st_force && !ld_hit;
  assign ld_issue = sched.IN_ldValid && ld_ready;
  assign st_issue = !ld_issue && st_elig;
  assign push     = sched.IN_stValid && st_ready_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fifo_vld_d = fifo_vld_q;
    starve_d   = starve_q;
    io_hold_d  = 1'b0;
    mem_en_d   = ld_issue || st_issue;
    mem_we_d   = st_issue;
    mem_addr_d = ld_issue ? sched.IN_ldAddr[31:2] : head_addr;

    if (st_issue) begin
      fifo_vld_d[head_q] = 1'b0;
      head_d             = head_q + 1'b1;
      io_hold_d          = st_io;
      starve_d           = '0;
    end else if (ld_issue && st_elig && (starve_q != STARVE_C)) begin
      starve_d = starve_q + 1'b1;
    end

    if (push) begin
      fifo_vld_d[tail_q] = 1'b1;
      tail_d             = tail_q + 1'b1;
    end

    case ({push, st_issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[tail_q] <= sched.IN_stAddr[31:2];
      fifo_data_q[tail_q] <= sched.IN_stData;
      fifo_mask_q[tail_q] <= sched.IN_stMask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fifo_vld_q  <= '0;
      starve_q    <= '0;
      io_hold_q   <= 1'b0;
      st_ready_q  <= 1'b1;
      empty_q     <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fifo_vld_q  <= fifo_vld_d;
      starve_q    <= starve_d;
      io_hold_q   <= io_hold_d;
      st_ready_q  <= (count_d < DEPTH_C);
      empty_q     <= (count_d == '0);
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= head_data;
      mem_wmask_q <= head_mask;
    end
  end

  // Tag rides alongside the read: command cycle, data-return cycle, then the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_v1_q   <= 1'b0;
      ld_v2_q   <= 1'b0;
      ld_vo_q   <= 1'b0;
      ld_t1_q   <= '0;
      ld_t2_q   <= '0;
      ld_to_q   <= '0;
      ld_data_q <= '0;
    end else begin
      ld_v1_q <= ld_issue;
      ld_t1_q <= sched.IN_ldTag;
      ld_v2_q <= ld_v1_q;
      ld_t2_q <= ld_t1_q;
      ld_vo_q <= ld_v2_q;
      ld_to_q <= ld_t2_q;
      if (ld_v2_q) begin
        ld_data_q <= sched.IN_memRData;
      end
    end
  end

  assign sched.OUT_stReady  = st_ready_q;
  assign sched.OUT_empty    = empty_q;
  assign sched.OUT_ldReady  = ld_ready;
  assign sched.OUT_ldValid  = ld_vo_q;
  assign sched.OUT_ldTag    = ld_to_q;
  assign sched.OUT_ldData   = ld_data_q;
  assign sched.OUT_memEn    = mem_en_q;
  assign sched.OUT_memWe    = mem_we_q;
  assign sched.OUT_memAddr  = mem_addr_q;
  assign sched.OUT_memWData = mem_wdata_q;
  assign sched.OUT_memWMask = mem_wmask_q;
endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb/tb_mem_port_scheduler.sv - self-checking bench for mem_port_scheduler against a queue-based reference model
module tb_mem_port_scheduler;
  localparam int DEPTH      = 4;
  localparam int HI_WATER   = 3;
  localparam int MAX_STARVE = 7;
  localparam int TAG_W      = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_scheduler_if #(.TAG_W(TAG_W)) bus ();

  mem_port_scheduler #(
    .DEPTH(DEPTH), .HI_WATER(HI_WATER), .MAX_STARVE(MAX_STARVE), .TAG_W(TAG_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sched(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } st_t;

  typedef struct {
    int               due;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } ld_t;

  st_t  mq[$];
  ld_t  lq[$];
  int   starve;
  bit   io_hold;
  logic [31:0] mmem [logic [29:0]];
  logic [31:0] tmem [logic [29:0]];
  bit          e_en, e_we;
  logic [29:0] e_addr;
  logic [31:0] e_wdata;
  logic [3:0]  e_mask;
  int cyc;
  int checks;
  int errors;

  function automatic logic [31:0] mdef(logic [29:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
    logic [31:0] w = old;
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  function automatic logic [31:0] mread(logic [29:0] a);
    return mmem.exists(a) ? mmem[a] : mdef(a);
  endfunction

  function automatic logic [31:0] tread(logic [29:0] a);
    return tmem.exists(a) ? tmem[a] : mdef(a);
  endfunction

  function automatic bit m_elig();
    if (mq.size() == 0) return 1'b0;
    if (mq[0].addr[31:24] == 8'hFF && (bus.IN_IO_busy || io_hold)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_hit();
    foreach (mq[i]) if (bus.IN_ldValid && mq[i].addr[31:2] == bus.IN_ldAddr[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    bit force_st = m_elig() && (mq.size() >= HI_WATER || starve >= MAX_STARVE);
    return !force_st && !m_hit();
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit exp_v;
    chk("stReady", bus.OUT_stReady, 64'(mq.size() < DEPTH));
    chk("empty", bus.OUT_empty, 64'(mq.size() == 0));
    chk("memEn", bus.OUT_memEn, 64'(e_en));
    if (e_en) begin
      chk("memWe", bus.OUT_memWe, 64'(e_we));
      chk("memAddr", bus.OUT_memAddr, 64'(e_addr));
      if (e_we) begin
        chk("memWData", bus.OUT_memWData, 64'(e_wdata));
        chk("memWMask", bus.OUT_memWMask, 64'(e_mask));
      end
    end
    exp_v = (lq.size() > 0) && (lq[0].due == cyc);
    chk("ldValid", bus.OUT_ldValid, 64'(exp_v));
    if (exp_v) begin
      chk("ldTag", bus.OUT_ldTag, 64'(lq[0].tag));
      chk("ldData", bus.OUT_ldData, 64'(lq[0].data));
      void'(lq.pop_front());
    end
    chk("ldReady", bus.OUT_ldReady, 64'(m_ready()));
  endtask

  task automatic model_step();
    bit  li, si, el, push;
    st_t s, n;
    ld_t l;
    el   = m_elig();
    li   = bus.IN_ldValid && m_ready();
    si   = !li && el;
    push = bus.IN_stValid && (mq.size() < DEPTH);
    e_en = li || si;
    e_we = si;
    if (li) begin
      e_addr = bus.IN_ldAddr[31:2];
      l.due  = cyc + 3;
      l.tag  = bus.IN_ldTag;
      l.data = mread(bus.IN_ldAddr[31:2]);
      lq.push_back(l);
    end else if (si) begin
      s       = mq.pop_front();
      e_addr  = s.addr[31:2];
      e_wdata = s.data;
      e_mask  = s.mask;
      mmem[s.addr[31:2]] = merge(mread(s.addr[31:2]), s.data, s.mask);
    end
    if (si) starve = 0;
    else if (el && li && starve < MAX_STARVE) starve++;
    io_hold = si && (s.addr[31:24] == 8'hFF);
    if (push) begin
      n.addr = bus.IN_stAddr;
      n.data = bus.IN_stData;
      n.mask = bus.IN_stMask;
      mq.push_back(n);
    end
  endtask

  task automatic tick();
    bit          c_en, c_we;
    logic [29:0] c_addr;
    logic [31:0] c_wd;
    logic [3:0]  c_m;
    @(negedge clk);
    check_outputs();
    model_step();
    c_en   = bus.OUT_memEn;
    c_we   = bus.OUT_memWe;
    c_addr = bus.OUT_memAddr;
    c_wd   = bus.OUT_memWData;
    c_m    = bus.OUT_memWMask;
    @(posedge clk);
    #1;
    cyc++;
    if (c_en && c_we) tmem[c_addr] = merge(tread(c_addr), c_wd, c_m);
    else if (c_en) bus.IN_memRData = tread(c_addr);
    else bus.IN_memRData = 32'hDEAD_BEEF;
  endtask

  task automatic idle_inputs();
    bus.IN_stValid = 1'b0;
    bus.IN_stAddr  = '0;
    bus.IN_stData  = '0;
    bus.IN_stMask  = 4'hF;
    bus.IN_ldValid = 1'b0;
    bus.IN_ldAddr  = '0;
    bus.IN_ldTag   = '0;
    bus.IN_IO_busy = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 14; i++) tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.IN_stValid = 1'b1;
    bus.IN_stAddr  = a;
    bus.IN_stData  = d;
    bus.IN_stMask  = 4'hF;
  endtask

  task automatic load(input logic [31:0] a, input logic [TAG_W-1:0] t);
    bus.IN_ldValid = 1'b1;
    bus.IN_ldAddr  = a;
    bus.IN_ldTag   = t;
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    chk("rst_memEn", bus.OUT_memEn, 64'd0);
    chk("rst_empty", bus.OUT_empty, 64'd1);
    chk("rst_stReady", bus.OUT_stReady, 64'd1);
    chk("rst_ldValid", bus.OUT_ldValid, 64'd0);
    mq.delete();
    lq.delete();
    starve  = 0;
    io_hold = 1'b0;
    e_en    = 1'b0;
    e_we    = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n, wr;
    bit done;
    checks = 0; errors = 0; cyc = 0; starve = 0; io_hold = 1'b0;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_mask = '0;
    idle_inputs();
    bus.IN_memRData = 32'hDEAD_BEEF;
    rst = 1'b1;
    #1;
    chk("reset_memEn", bus.OUT_memEn, 64'd0);
    chk("reset_memWe", bus.OUT_memWe, 64'd0);
    chk("reset_stReady", bus.OUT_stReady, 64'd1);
    chk("reset_empty", bus.OUT_empty, 64'd1);
    chk("reset_ldValid", bus.OUT_ldValid, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    load(32'h100, 6'd5);
    tick();
    chk("idle_ld_cmd", {bus.OUT_memEn, bus.OUT_memWe, bus.OUT_memAddr}, {1'b1, 1'b0, 30'h40});
    idle_inputs();
    tick();
    tick();
    chk("idle_ld_valid", bus.OUT_ldValid, 64'd1);
    chk("idle_ld_tag", bus.OUT_ldTag, 64'd5);
    chk("idle_ld_data", bus.OUT_ldData, 64'(mdef(30'h40)));
    drain();

    load(32'h1000, 6'd1);
    store(32'h2000, 32'hA0);
    tick();
    store(32'h2004, 32'hA1);
    tick();
    store(32'h2008, 32'hA2);
    tick();
    bus.IN_stValid = 1'b0;
    #1;
    chk("wm_ldReady_low", bus.OUT_ldReady, 64'd0);
    tick();
    chk("wm_first_write", {bus.OUT_memEn, bus.OUT_memWe, bus.OUT_memAddr}, {1'b1, 1'b1, 30'h800});
    #1;
    chk("wm_ldReady_resume", bus.OUT_ldReady, 64'd1);
    drain();

    load(32'h1004, 6'd2);
    store(32'h3000, 32'h5555_AAAA);
    tick();
    bus.IN_stValid = 1'b0;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (bus.OUT_ldReady) begin
        n++;
        tick();
      end else done = 1'b1;
    end
    chk("starve_loads", 64'(n), 64'd7);
    chk("starve_bound", 64'(done), 64'd1);
    tick();
    chk("starve_write", {bus.OUT_memEn, bus.OUT_memWe, bus.OUT_memAddr}, {1'b1, 1'b1, 30'hC00});
    #1;
    chk("starve_resume", bus.OUT_ldReady, 64'd1);
    drain();

    store(32'h200, 32'hCAFE_0001);
    tick();
    bus.IN_stValid = 1'b0;
    load(32'h202, 6'd9);
    #1;
    chk("haz_ldReady_low", bus.OUT_ldReady, 64'd0);
    tick();
    chk("haz_write", {bus.OUT_memEn, bus.OUT_memWe, bus.OUT_memAddr}, {1'b1, 1'b1, 30'h80});
    #1;
    chk("haz_ldReady_high", bus.OUT_ldReady, 64'd1);
    tick();
    bus.IN_ldValid = 1'b0;
    chk("haz_read", {bus.OUT_memEn, bus.OUT_memWe, bus.OUT_memAddr}, {1'b1, 1'b0, 30'h80});
    tick();
    tick();
    chk("haz_ld_data", {bus.OUT_ldValid, bus.OUT_ldData}, {1'b1, 32'hCAFE_0001});
    drain();

    bus.IN_IO_busy = 1'b1;
    store(32'hFF00_0000, 32'h1);
    tick();
    store(32'hFF00_0004, 32'h2);
    tick();
    bus.IN_stValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("io_busy_hold", bus.OUT_memEn, 64'd0);
    end
    bus.IN_IO_busy = 1'b0;
    tick();
    chk("io_first", {bus.OUT_memEn, bus.OUT_memWe, bus.OUT_memAddr}, {1'b1, 1'b1, 30'h3FC0_0000});
    tick();
    chk("io_gap", bus.OUT_memEn, 64'd0);
    tick();
    chk("io_second", {bus.OUT_memEn, bus.OUT_memWe, bus.OUT_memAddr}, {1'b1, 1'b1, 30'h3FC0_0001});
    drain();

    bus.IN_IO_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      store(32'hFF00_0010 + 32'(4 * i), 32'h100 + 32'(i));
      tick();
    end
    chk("full_stReady", bus.OUT_stReady, 64'd0);
    store(32'hFF00_0100, 32'hBAD);
    tick();
    bus.IN_stValid = 1'b0;
    chk("full_ignored_stReady", bus.OUT_stReady, 64'd0);
    chk("full_not_empty", bus.OUT_empty, 64'd0);
    bus.IN_IO_busy = 1'b0;
    wr = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.OUT_memEn && bus.OUT_memWe) wr++;
    end
    chk("full_write_count", 64'(wr), 64'(DEPTH));
    drain();

    bus.IN_IO_busy = 1'b1;
    store(32'hFF00_0020, 32'h11);
    tick();
    store(32'hFF00_0024, 32'h22);
    tick();
    bus.IN_stValid = 1'b0;
    load(32'h500, 6'd3);
    tick();
    bus.IN_ldValid = 1'b0;
    mid_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_ldValid", bus.OUT_ldValid, 64'd0);
    end

    for (int i = 0; i < 800; i++) begin
      if (i == 400) mid_reset();
      bus.IN_stValid = ($urandom_range(0, 9) < 4);
      bus.IN_stAddr  = (($urandom_range(0, 9) < 2) ? 32'hFF00_0000 + 32'(4 * $urandom_range(0, 3))
                                                    : 32'h100 + 32'(4 * $urandom_range(0, 7)))
                       | 32'($urandom_range(0, 3));
      bus.IN_stData  = $urandom;
      bus.IN_stMask  = 4'($urandom_range(0, 15));
      bus.IN_ldValid = ($urandom_range(0, 9) < 6);
      bus.IN_ldAddr  = (32'h100 + 32'(4 * $urandom_range(0, 7))) | 32'($urandom_range(0, 3));
      bus.IN_ldTag   = TAG_W'($urandom);
      bus.IN_IO_busy = ($urandom_range(0, 9) < 3);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
